// File: rtl/p2_motion_pkg.sv
// Shared motion definitions for the player position integrators:
// state encoding, default arena bounds and the wall clamp.
package p2_motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_LUNGE = 2'd2,
    ST_KNOCK = 2'd3
  } motion_state_t;

  localparam int X_MIN    = 0;
  localparam int X_MAX    = 638;
  localparam int SPRITE_W = 125;

  // Left edge after applying delta, held inside [lo, hi - w].
  function automatic logic signed [31:0] clamp_x(
    input logic signed [31:0] xpos,
    input logic signed [31:0] delta,
    input int                 lo,
    input int                 hi,
    input int                 w
  );
    logic signed [31:0] nx;
    nx = xpos + delta;
    if (nx < lo) begin
      nx = lo;
    end else if (nx + w > hi) begin
      nx = hi - w;
    end
    return nx;
  endfunction

endpackage

// File: rtl/x_clamp.sv
// Combinational wall clamp: next left edge and the displacement actually applied.
module x_clamp
  import p2_motion_pkg::*;
#(
  parameter int LO = X_MIN,
  parameter int HI = X_MAX,
  parameter int W  = SPRITE_W
) (
  input  logic signed [31:0] xpos,
  input  logic signed [31:0] delta,
  output logic signed [31:0] nx,
  output logic signed [31:0] applied_delta
);

  always_comb begin
    nx            = clamp_x(xpos, delta, LO, HI, W);
    applied_delta = nx - xpos;
  end

endmodule

// File: rtl/p2_position_integrator.sv
// Player-2 horizontal position integrator: per-frame source selection
// (knockback > lunge > walk > idle), wall clamp and registered X position.
module p2_position_integrator
  import p2_motion_pkg::*;
#(
  parameter int X_START      = 400,
  parameter int WALK_SPEED   = 2,
  parameter int KNOCK_SPEED  = 4,
  parameter int KNOCK_FRAMES = 8
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               crouch,
  input  logic signed [31:0] lunge_motion,
  input  logic               hit,
  output logic signed [31:0] Xpos,
  output logic signed [31:0] X_Motion,
  output logic               knock_active
);

  localparam int unsigned CNT_W = $clog2(KNOCK_FRAMES + 1);

  motion_state_t      state_q, state_d;
  logic [CNT_W-1:0]   knock_cnt_q, knock_cnt_d;
  logic               hit_pending_q;
  logic               hit_taken_c;
  logic signed [31:0] delta_c;
  logic signed [31:0] nx_c;
  logic signed [31:0] applied_c;

  // State and output registers; everything but hit capture moves on frame_tick only.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      knock_cnt_q   <= '0;
      hit_pending_q <= 1'b0;
      Xpos          <= 32'(X_START);
      X_Motion      <= '0;
      knock_active  <= 1'b0;
    end else begin
      hit_pending_q <= frame_tick ? 1'b0 : (hit_pending_q | hit);
      if (frame_tick) begin
        state_q      <= state_d;
        knock_cnt_q  <= knock_cnt_d;
        Xpos         <= nx_c;
        X_Motion     <= applied_c;
        knock_active <= (state_d == ST_KNOCK);
      end
    end
  end

  // Next-state: source priority evaluated on the tick cycle.
  always_comb begin
    hit_taken_c = hit_pending_q | hit;
    state_d     = state_q;
    if (frame_tick) begin
      if (hit_taken_c || (knock_cnt_q != '0)) begin
        state_d = ST_KNOCK;
      end else if (lunge_motion != '0) begin
        state_d = ST_LUNGE;
      end else if ((move_left ^ move_right) && !crouch) begin
        state_d = ST_WALK;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Raw displacement for the selected source and knockback frame counter.
  always_comb begin
    delta_c     = '0;
    knock_cnt_d = knock_cnt_q;
    case (state_d)
      ST_KNOCK: delta_c = 32'(-KNOCK_SPEED);
      ST_LUNGE: delta_c = lunge_motion;
      ST_WALK:  delta_c = move_left ? 32'(-WALK_SPEED) : 32'(WALK_SPEED);
      default:  delta_c = '0;
    endcase
    if (frame_tick) begin
      if (hit_taken_c) begin
        knock_cnt_d = CNT_W'(KNOCK_FRAMES - 1);
      end else if (knock_cnt_q != '0) begin
        knock_cnt_d = knock_cnt_q - CNT_W'(1);
      end
    end
  end

  x_clamp #(
    .LO (X_MIN),
    .HI (X_MAX),
    .W  (SPRITE_W)
  ) u_clamp (
    .xpos          (Xpos),
    .delta         (delta_c),
    .nx            (nx_c),
    .applied_delta (applied_c)
  );

endmodule

// File: tb/tb_p2_position_integrator.sv
// Scoreboard bench for p2_position_integrator: a reference model pushes the
// expected post-tick outputs, which are popped and compared after each tick.
module tb_p2_position_integrator;

  logic               clk = 1'b0;
  logic               Reset_n;
  logic               frame_tick;
  logic               move_left;
  logic               move_right;
  logic               crouch;
  logic signed [31:0] lunge_motion;
  logic               hit;
  logic signed [31:0] Xpos;
  logic signed [31:0] X_Motion;
  logic               knock_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   x;
    int   m;
    logic k;
  } exp_t;

  exp_t sb[$];

  // reference model state
  int m_x;
  int m_cnt;
  bit m_pend;

  always #5 clk = ~clk;

  p2_position_integrator dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .move_left    (move_left),
    .move_right   (move_right),
    .crouch       (crouch),
    .lunge_motion (lunge_motion),
    .hit          (hit),
    .Xpos         (Xpos),
    .X_Motion     (X_Motion),
    .knock_active (knock_active)
  );

  task automatic model_reset();
    m_x    = 400;
    m_cnt  = 0;
    m_pend = 0;
    sb.delete();
  endtask

  task automatic model_tick(input bit ml, input bit mr, input bit cr, input int lm, input bit h);
    int   delta;
    int   nx;
    exp_t e;
    bit   knock;
    knock = 0;
    if (m_pend || h) begin
      knock = 1; m_cnt = 7; delta = -4;
    end else if (m_cnt > 0) begin
      knock = 1; m_cnt--; delta = -4;
    end else if (lm != 0) begin
      delta = lm;
    end else if ((ml != mr) && !cr) begin
      delta = ml ? -2 : 2;
    end else begin
      delta = 0;
    end
    m_pend = 0;
    nx = m_x + delta;
    if (nx < 0) nx = 0;
    else if (nx + 125 > 638) nx = 513;
    e.x = nx;
    e.m = nx - m_x;
    e.k = knock;
    m_x = nx;
    sb.push_back(e);
  endtask

  // One frame: drive inputs with frame_tick, then compare and check hold.
  task automatic tick(input bit ml, input bit mr, input bit cr, input int lm, input bit h);
    exp_t e;
    move_left    = ml;
    move_right   = mr;
    crouch       = cr;
    lunge_motion = lm;
    hit          = h;
    frame_tick   = 1'b1;
    model_tick(ml, mr, cr, lm, h);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    hit        = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb.pop_front();
      if (Xpos !== e.x || X_Motion !== e.m || knock_active !== e.k) begin
        errors++;
        $display("FAIL tick_outputs: Xpos=%0d X_Motion=%0d knock=%b, expected %0d %0d %b",
                 Xpos, X_Motion, knock_active, e.x, e.m, e.k);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (Xpos !== e.x || X_Motion !== e.m || knock_active !== e.k) begin
        errors++;
        $display("FAIL hold_between_ticks: Xpos=%0d X_Motion=%0d knock=%b, expected %0d %0d %b",
                 Xpos, X_Motion, knock_active, e.x, e.m, e.k);
      end
    end
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    m_pend = 1;
    @(posedge clk); #1;
    hit = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #23;
    checks++;
    if (Xpos !== 400 || X_Motion !== 0 || knock_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: Xpos=%0d X_Motion=%0d knock=%b, expected 400 0 0",
               Xpos, X_Motion, knock_active);
    end
    @(posedge clk); #1;
    Reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_walk();
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    checks++;
    if (Xpos !== 406) begin
      errors++;
      $display("FAIL walk_right_3: Xpos=%0d expected 406", Xpos);
    end
    tick(1, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    checks++;
    if (Xpos !== 406) begin
      errors++;
      $display("FAIL walk_both_crouch: Xpos=%0d expected 406", Xpos);
    end
  endtask

  task automatic test_wall();
    tick(0, 0, 1, 102, 0);
    tick(0, 0, 0, 8, 0);
    checks++;
    if (Xpos !== 513 || X_Motion !== 5) begin
      errors++;
      $display("FAIL right_wall_partial: Xpos=%0d X_Motion=%0d expected 513 5", Xpos, X_Motion);
    end
    tick(1, 0, 0, 8, 0);
    checks++;
    if (Xpos !== 513 || X_Motion !== 0) begin
      errors++;
      $display("FAIL right_wall_pinned: Xpos=%0d X_Motion=%0d expected 513 0", Xpos, X_Motion);
    end
  endtask

  task automatic test_knock();
    int kticks;
    tick(0, 0, 0, -413, 0);
    pulse_hit();
    kticks = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, 0, 0);
      if (knock_active === 1'b1) kticks++;
      if (i == 7) begin
        checks++;
        if (Xpos !== 68) begin
          errors++;
          $display("FAIL knock_end_pos: Xpos=%0d expected 68", Xpos);
        end
      end
    end
    checks++;
    if (kticks != 8) begin
      errors++;
      $display("FAIL knock_len: knock ticks=%0d expected 8", kticks);
    end
  endtask

  task automatic test_rehit();
    int kticks;
    tick(0, 0, 0, -52, 0);
    pulse_hit();
    kticks = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1, 0, 0, 0, 0);
      if (knock_active === 1'b1) kticks++;
      if (i == 4) pulse_hit();
    end
    checks++;
    if (kticks != 13 || Xpos !== 0) begin
      errors++;
      $display("FAIL rehit_extend: knock ticks=%0d Xpos=%0d expected 13 0", kticks, Xpos);
    end
  endtask

  task automatic test_back_to_back();
    tick(0, 1, 0, 0, 1);
    checks++;
    if (knock_active !== 1'b1 || X_Motion !== 0) begin
      errors++;
      $display("FAIL hit_on_tick: knock=%b X_Motion=%0d expected 1 0", knock_active, X_Motion);
    end
    tick(0, 0, 0, 30, 0);
    tick(0, 0, 0, 30, 0);
  endtask

  task automatic test_reset_mid_knock();
    pulse_hit();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    pulse_hit();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Xpos !== 400 || X_Motion !== 0 || knock_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_knock: Xpos=%0d X_Motion=%0d knock=%b expected 400 0 0",
               Xpos, X_Motion, knock_active);
    end
    @(posedge clk); #1;
    Reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    tick(0, 0, 0, 0, 0);
    checks++;
    if (knock_active !== 1'b0 || Xpos !== 400) begin
      errors++;
      $display("FAIL post_reset_idle: knock=%b Xpos=%0d expected 0 400", knock_active, Xpos);
    end
  endtask

  initial begin
    frame_tick   = 1'b0;
    move_left    = 1'b0;
    move_right   = 1'b0;
    crouch       = 1'b0;
    lunge_motion = '0;
    hit          = 1'b0;
    model_reset();
    test_reset();
    test_walk();
    test_wall();
    test_knock();
    test_rehit();
    test_back_to_back();
    test_reset_mid_knock();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p2_position_integrator.md
# p2_position_integrator

Per-frame horizontal position integrator for player 2. Consumes the signed lunge displacement produced by the punch-lunge controller together with walk and hit inputs. Each frame it selects one motion source, clamps the result against the arena walls and updates the registered X position. That position is fed back to the lunge controller for its wall-distance check and forwarded to the sprite/collision logic.

## Interface
- X_MIN, 0, left arena bound (pixels)
- X_MAX, 638, right arena bound (pixels)
- SPRITE_W, 125, sprite width; the right edge is Xpos + SPRITE_W
- X_START, 400, Xpos after reset
- WALK_SPEED, 2, walk displacement per frame
- KNOCK_SPEED, 4, knockback displacement per frame (applied toward −X)
- KNOCK_FRAMES, 8, knockback duration in frames

Ports:
- clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse, once per video frame
- move_left  in  1  walk-left request (level)
- move_right  in  1  walk-right request (level)
- crouch  in  1  crouch held (level)
- lunge_motion  in  int (32, signed)  lunge displacement for the current frame; 0 when no lunge
- hit  in  1  one-cycle pulse when player 2 is struck
- Xpos  out  int (32, signed)  registered left-edge X position
- X_Motion  out  int (32, signed)  post-clamp displacement applied at the last frame update
- knock_active  out  1  high while in KNOCK

## Operation
- State machine with four states: IDLE, WALK, LUNGE, KNOCK. The state is recomputed only on cycles with frame_tick=1.
- Source priority at each tick, highest first:
  - KNOCK, when knock_cnt>0 or hit_pending
  - LUNGE, when lunge_motion≠0
  - WALK, when exactly one of move_left/move_right is set and crouch=0
  - IDLE otherwise
- Raw delta per state:
  - KNOCK: −KNOCK_SPEED
  - LUNGE: lunge_motion
  - WALK: −WALK_SPEED for left, +WALK_SPEED for right
  - IDLE: 0
- Both walk inputs set, or crouch held, gives IDLE. Crouch does not suppress LUNGE or KNOCK.
- hit_pending is set by a hit pulse and cleared at the next frame_tick. A hit on the same cycle as frame_tick is taken at that tick.
- On taking a hit, knock_cnt loads KNOCK_FRAMES−1 and the knock delta applies that same frame. knock_cnt then decrements once per tick in KNOCK.
- A new hit during KNOCK reloads knock_cnt; the state stays KNOCK.
- Clamp, computed in 32-bit signed arithmetic with no truncation:
  - nx = Xpos + delta
  - if nx < X_MIN, then nx = X_MIN
  - else if nx + SPRITE_W > X_MAX, then nx = X_MAX − SPRITE_W (513 with defaults)
- X_Motion = nx − Xpos, so it is 0 when the player is pinned against a wall.
- Reset (asynchronous, any time, including mid-lunge or mid-knock):
  - Xpos = X_START
  - X_Motion = 0
  - state = IDLE
  - knock_cnt = 0
  - hit_pending = 0
  - knock_active = 0

## Timing
- All outputs are registered. Xpos, X_Motion and knock_active take their new values on the clock edge that samples frame_tick=1 and are visible the following cycle.
- Outputs hold constant between ticks.
- lunge_motion, move_*, crouch are sampled only on the frame_tick cycle. hit is sampled every cycle.
- The lunge controller reads Xpos, so it sees the position from the previous frame update. One frame of feedback latency is intended.
- knock_active is high for exactly KNOCK_FRAMES ticks after a single hit.

## Structure
- Shared package p2_motion_pkg holds:
  - the state enum typedef
  - default arena constants X_MIN, X_MAX, SPRITE_W
  - a clamp function, to be reused by the player-1 integrator
- One sub-module, x_clamp: purely combinational. Inputs: Xpos, delta. Outputs: nx, applied delta.
- Target RTL size is about 150 lines.

## Test plan
- Reset release, no input, 5 ticks → Xpos=400 and X_Motion=0 throughout.
- move_right for 3 ticks from 400 → Xpos goes 402, 404, 406. move_left and move_right together → Xpos unchanged.
- Xpos=508 with lunge_motion=8 → Xpos=513, X_Motion=5. A further lunge_motion=8 → Xpos=513, X_Motion=0.
- hit pulse between ticks at Xpos=100 → knock_active high for 8 ticks, Xpos reaches 68. Walk input is ignored throughout.
- Second hit at knock tick 5 → knock extends to 13 ticks total. From Xpos=20, Xpos clamps at 0.
- Reset_n asserted mid-knock, between ticks → outputs return to their reset values immediately. The next tick after release is processed as IDLE.
